// File: rtl/bus_pkg.sv
// Shared types and helpers for the CPU data-side bus bridge: access sizes,
// target selection, fault causes, address windows and lane steering.
package bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_MMIO = 2'd2
  } target_t;

  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_UNMAPPED   = 2'b10;

  // Both windows are 64 KiB, so a window is identified by addr[31:16].
  localparam int unsigned WINDOW_BITS   = 16;
  localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'h8000_0000;

  // Bookkeeping for the single load that may be in flight.
  typedef struct packed {
    logic       pending;
    target_t    target;
    logic [1:0] offset;
    logic [1:0] size;
    logic       zero_ext;
    logic       err;
  } load_track_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  // Store data is replicated so the target only needs byte enables to place it.
  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/half lane out of a
// memory word and sign- or zero-extends it; words pass through unchanged.
module load_align
  import bus_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    byte_lane = word[7:0];
    case (offset)
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      2'd3:    byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];

    result = word;
    case (size)
      SIZE_BYTE: result = zero_ext ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SIZE_HALF: result = zero_ext ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/data_bus_bridge.sv
// CPU data-port bridge: decodes loads/stores onto RAM or MMIO, blocks faulting
// accesses, tracks the outstanding load and latches the first fault.
module data_bus_bridge
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rerr,
  output logic [13:0] tgt_address,
  output logic [3:0]  tgt_byteena,
  output logic [31:0] tgt_data,
  output logic        tgt_wren,
  output logic        ram_clken,
  output logic        mmio_clken,
  input  logic [31:0] ram_q,
  input  logic [31:0] mmio_q,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  input  logic        fault_clear
);

  logic        hit_ram;
  logic        hit_mmio;
  logic        misaligned;
  logic        unmapped;
  logic        fault;
  logic        good;
  logic [1:0]  cause;
  load_track_t track;
  load_track_t track_next;
  logic [31:0] q_sel;
  logic [31:0] aligned;

  always_comb begin
    hit_ram    = cpu_addr[31:WINDOW_BITS] == RAM_BASE[31:WINDOW_BITS];
    hit_mmio   = cpu_addr[31:WINDOW_BITS] == MMIO_BASE[31:WINDOW_BITS];
    misaligned = is_misaligned(cpu_size, cpu_addr[1:0]);
    unmapped   = !hit_ram && !hit_mmio;
    fault      = cpu_req && (misaligned || unmapped);
    good       = cpu_req && !fault;
    cause      = misaligned ? CAUSE_MISALIGNED : CAUSE_UNMAPPED;
  end

  assign tgt_address = cpu_addr[15:2];
  assign tgt_byteena = byte_enables(cpu_size, cpu_addr[1:0]);
  assign tgt_data    = replicate_store(cpu_size, cpu_wdata);

  // Strobes are gated by reset so nothing reaches a target while it is held.
  assign ram_clken  = good && hit_ram && !reset;
  assign mmio_clken = good && !hit_ram && hit_mmio && !reset;
  assign tgt_wren   = good && cpu_we && !reset;

  always_comb begin
    track_next = '0;
    if (cpu_req && !cpu_we) begin
      track_next.pending  = 1'b1;
      track_next.target   = fault ? TGT_NONE : (hit_ram ? TGT_RAM : TGT_MMIO);
      track_next.offset   = cpu_addr[1:0];
      track_next.size     = cpu_size;
      track_next.zero_ext = cpu_unsigned;
      track_next.err      = fault;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      track <= '0;
    end else begin
      track <= track_next;
    end
  end

  assign q_sel = (track.target == TGT_MMIO) ? mmio_q : ram_q;

  load_align u_load_align (
    .word     (q_sel),
    .offset   (track.offset),
    .size     (track.size),
    .zero_ext (track.zero_ext),
    .result   (aligned)
  );

  assign cpu_rvalid = track.pending;
  assign cpu_rerr   = track.pending && track.err;
  assign cpu_rdata  = (track.pending && !track.err) ? aligned : 32'h0;

  // A new fault wins over a simultaneous clear; otherwise the first fault sticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_valid <= 1'b0;
      fault_cause <= CAUSE_NONE;
      fault_addr  <= 32'h0;
    end else if (fault && (!fault_valid || fault_clear)) begin
      fault_valid <= 1'b1;
      fault_cause <= cause;
      fault_addr  <= cpu_addr;
    end else if (fault_clear) begin
      fault_valid <= 1'b0;
    end
  end

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Routes load/store requests from the CPU data port to either the data RAM or the `mmio` peripheral block, both of which are single-cycle synchronous memories with word index, byte enables and clock enable. Generates byte enables, replicates store data and tracks the one outstanding read so that load data can be aligned and sign/zero-extended when it returns. Misaligned and unmapped accesses are detected and blocked from reaching either target, and the first such fault is latched in a sticky fault register.

## Interface
Parameters:
- `RAM_BASE`, 32'h0000_0000: RAM window base; window size 64 KiB.
- `MMIO_BASE`, 32'h8000_0000: MMIO window base; window size 64 KiB.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  access request valid this cycle.
- `cpu_addr`  in  32  byte address.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as misaligned.
- `cpu_unsigned`  in  1  zero-extend load (lbu/lhu).
- `cpu_wdata`  in  32  store data, right-aligned.
- `cpu_rvalid`  out  1  load response valid.
- `cpu_rdata`  out  32  aligned, extended load data.
- `cpu_rerr`  out  1  response belongs to a faulting load.
- `tgt_address`  out  14  word index `cpu_addr[15:2]`, shared by both targets.
- `tgt_byteena`  out  4  byte enables, shared.
- `tgt_data`  out  32  replicated store data, shared.
- `tgt_wren`  out  1  store strobe, shared.
- `ram_clken`, `mmio_clken`  out  1 each  per-target select.
- `ram_q`, `mmio_q`  in  32 each  target read data, valid one cycle after clken.
- `fault_valid`  out  1  sticky fault present.
- `fault_cause`  out  2  01 = misaligned, 10 = unmapped.
- `fault_addr`  out  32  address of first fault.
- `fault_clear`  in  1  clears sticky fault.

## Operation
- Decode: RAM if `cpu_addr[31:16] == RAM_BASE[31:16]`, MMIO if `== MMIO_BASE[31:16]`, else unmapped.
- Misaligned: half with `addr[0]=1`; word with `addr[1:0]!=0`; size 3. Misaligned takes priority over unmapped for cause.
- Byte enables: byte -> `1 << addr[1:0]`; half -> `addr[1] ? 1100 : 0011`; word -> 1111.
- Store data: byte -> `{4{wdata[7:0]}}`; half -> `{2{wdata[15:0]}}`; word -> as is.
- Good request: exactly one of `ram_clken`/`mmio_clken` = 1; `tgt_wren = cpu_we`. Faulting request: both clken and `tgt_wren` = 0.
- Load bookkeeping register: pending, target (ram/mmio/none), `addr[1:0]`, size, unsigned, err. Loaded on every load request, including faulting ones; cleared when no load issued.
- Response (combinational from pending + q): select lane by offset, sign-extend unless `unsigned`; word passes through. Faulting load returns `rdata=0`, `rerr=1`.
- Stores produce no response.
- Fault register: on a faulting request while `fault_valid=0`, capture cause and addr, set `fault_valid`. Later faults ignored until cleared. `fault_clear` and a new fault in the same cycle: new fault captured.

## Timing
- Request accepted every cycle; no backpressure; back-to-back loads pipelined, one response per cycle.
- Target outputs combinational from request in the same cycle N.
- Load response `cpu_rvalid=1` in cycle N+1 only, data muxed from `*_q` that cycle.
- Fault register visible in N+1.
- Reset (asynchronous): pending cleared, `cpu_rvalid=0`, `fault_valid=0`, `fault_cause=0`, `fault_addr=0`; while `reset=1`, `ram_clken`, `mmio_clken`, `tgt_wren` forced 0. Load issued in the cycle reset asserts never responds.

## Structure
- Shared package `bus_pkg`: `size_t` enum (BYTE, HALF, WORD), `target_t` enum (NONE, RAM, MMIO), `fault_cause_t` constants, window base/size constants.
- One sub-module natural: `load_align` (combinational: word, offset, size, unsigned -> 32-bit result), reusable for instruction-side loads.

## Test plan
- `sw` 0x0000_0010 <- 0xDEADBEEF, then `lw` 0x0000_0010 -> `tgt_address=4`, `byteena=1111`; next cycle `rvalid=1`, `rdata=0xDEADBEEF`, `rerr=0`.
- `sb` 0x8000_0005 data 0x0000_00A5 -> `mmio_clken=1`, `ram_clken=0`, `tgt_address=1`, `byteena=0010`, `tgt_data=0xA5A5A5A5`, `wren=1`.
- RAM word 0x80FF_1234 at 0x0: `lb` 0x3 -> 0xFFFF_FF80; `lbu` 0x3 -> 0x0000_0080; `lh` 0x2 -> 0xFFFF_80FF; `lhu` 0x0 -> 0x0000_1234.
- `lw` 0x0000_0002 -> no clken; next cycle `rerr=1`, `rdata=0`, `fault_cause=01`, `fault_addr=0x2`; then `sw` 0x4000_0000 -> fault unchanged; `fault_clear` -> `fault_valid=0`.
- Back-to-back `lw` RAM 0x0 then `lw` MMIO 0x8000_0000 -> `rvalid` in two consecutive cycles, data from `ram_q` then `mmio_q`.
- Issue `lw`, assert `reset` mid-cycle -> `rvalid` stays 0; after release all outputs at reset values.
